fifo_wr_ctrl: RTL and testbench

Write-side controller of the asynchronous FIFO; the counterpart of the FIFO read controller.
- Runs entirely in the write clock domain.
- Owns the RAM write pointer and produces the full flag, the write-port data count, the almost-full flag and the qualified RAM write enable.
- Reports a registered write acknowledge and a sticky overflow error.
- Publishes a Gray-coded copy of the write pointer for synchronisation into the read domain.

---
 rtl/fifo_wr_ctrl.sv | 91 +++++++++
 tb/tb_fifo_wr_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: owns the RAM write pointer,
// derives full/almost-full/count from the synchronised read pointer, and publishes a Gray pointer.
module fifo_wr_ctrl #(
  parameter int RAM_ADDR_WIDTH = 5,
  parameter int WR_IND         = 4,
  parameter int WR_CNT_WIDTH   = RAM_ADDR_WIDTH + 1 - $clog2(WR_IND),
  parameter int ALMOST_FULL_TH = 6
) (
  input  logic                      wr_clk,
  input  logic                      wr_rst_n,
  input  logic                      wr_en,
  input  logic                      ovf_clr,
  input  logic [RAM_ADDR_WIDTH:0]   rd_ptr_sync,
  output logic [RAM_ADDR_WIDTH:0]   wr_ptr,
  output logic [RAM_ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                      fifo_full,
  output logic                      almost_full,
  output logic [WR_CNT_WIDTH-1:0]   wr_data_count,
  output logic                      ram_wr_en,
  output logic                      wr_ack,
  output logic                      overflow
);

  localparam int PTR_W = RAM_ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0]        PTR_INC  = PTR_W'(WR_IND);
  localparam logic [PTR_W-1:0]        FULL_LIM = PTR_W'((2 ** RAM_ADDR_WIDTH) - WR_IND);
  localparam logic [WR_CNT_WIDTH-1:0] AF_TH    = WR_CNT_WIDTH'(ALMOST_FULL_TH);

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        wr_ptr_d;
  logic [PTR_W-1:0]        wr_gray_q;
  logic                    wr_ack_q;
  logic                    overflow_q;
  logic                    overflow_d;
  logic [PTR_W-1:0]        wr_ram_cnt_s;
  logic [WR_CNT_WIDTH-1:0] wr_data_count_s;
  logic                    fifo_full_s;
  logic                    ram_wr_en_s;

  // Occupancy, flags, write qualification and next-state values.
  // Modular subtraction handles the lap bit; full means less than one write word of free space.
  always_comb begin
    wr_ram_cnt_s    = wr_ptr_q - rd_ptr_sync;
    wr_data_count_s = wr_ram_cnt_s[RAM_ADDR_WIDTH -: WR_CNT_WIDTH];
    fifo_full_s     = (wr_ram_cnt_s > FULL_LIM);
    ram_wr_en_s     = wr_en & ~fifo_full_s;
    wr_ptr_d        = wr_ptr_q;
    overflow_d      = overflow_q;
    if (ram_wr_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_INC;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (wr_en & fifo_full_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers; Gray copy is taken from the next pointer so it tracks wr_ptr with no lag.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      wr_gray_q  <= {PTR_W{1'b0}};
      wr_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_gray_q  <= bin2gray(wr_ptr_d);
      wr_ack_q   <= ram_wr_en_s;
      overflow_q <= overflow_d;
    end
  end

  assign wr_ptr        = wr_ptr_q;
  assign wr_ptr_gray   = wr_gray_q;
  assign fifo_full     = fifo_full_s;
  assign almost_full   = (wr_data_count_s >= AF_TH);
  assign wr_data_count = wr_data_count_s;
  assign ram_wr_en     = ram_wr_en_s;
  assign wr_ack        = wr_ack_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Bench for fifo_wr_ctrl: directed scenarios plus random traffic, checked against
// a model that tracks total units written and read as plain integers.
module tb_fifo_wr_ctrl;

  logic       wr_clk;
  logic       wr_rst_n;
  logic       wr_en;
  logic       ovf_clr;
  logic [5:0] rd_ptr_sync;
  logic [5:0] wr_ptr;
  logic [5:0] wr_ptr_gray;
  logic       fifo_full;
  logic       almost_full;
  logic [3:0] wr_data_count;
  logic       ram_wr_en;
  logic       wr_ack;
  logic       overflow;

  int n_chk;
  int n_pass;
  int wtot;
  int rtot;
  int exp_ack;
  int exp_ovf;

  fifo_wr_ctrl dut (
    .wr_clk        (wr_clk),
    .wr_rst_n      (wr_rst_n),
    .wr_en         (wr_en),
    .ovf_clr       (ovf_clr),
    .rd_ptr_sync   (rd_ptr_sync),
    .wr_ptr        (wr_ptr),
    .wr_ptr_gray   (wr_ptr_gray),
    .fifo_full     (fifo_full),
    .almost_full   (almost_full),
    .wr_data_count (wr_data_count),
    .ram_wr_en     (ram_wr_en),
    .wr_ack        (wr_ack),
    .overflow      (overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
  endtask

  // Compares every output against the model for the current cycle; returns whether a write is accepted.
  task automatic check_all(input logic we, output logic acc, output logic full);
    int occ;
    int p;
    occ  = wtot - rtot;
    p    = wtot % 64;
    full = (32 - occ) < 4;
    acc  = we && !full;
    chk("wr_ptr",        32'(wr_ptr),        p);
    chk("wr_ptr_gray",   32'(wr_ptr_gray),   p ^ (p / 2));
    chk("fifo_full",     32'(fifo_full),     int'(full));
    chk("wr_data_count", 32'(wr_data_count), occ / 4);
    chk("almost_full",   32'(almost_full),   int'((occ / 4) >= 6));
    chk("ram_wr_en",     32'(ram_wr_en),     int'(acc));
    chk("wr_ack",        32'(wr_ack),        exp_ack);
    chk("overflow",      32'(overflow),      exp_ovf);
  endtask

  // One clock cycle: called just after a rising edge, reads advance first, checks at the falling edge.
  task automatic do_cycle(input logic we, input logic clr, input int radv);
    logic acc;
    logic full;
    rtot        = rtot + radv;
    wr_en       = we;
    ovf_clr     = clr;
    rd_ptr_sync = 6'(rtot % 64);
    @(negedge wr_clk);
    check_all(we, acc, full);
    @(posedge wr_clk);
    #1;
    if (acc) wtot = wtot + 4;
    exp_ack = int'(acc);
    if (we && full) exp_ovf = 1;
    else if (clr) exp_ovf = 0;
  endtask

  task automatic model_reset();
    wtot    = 0;
    rtot    = 0;
    exp_ack = 0;
    exp_ovf = 0;
  endtask

  initial begin
    int guard;
    int occ;
    int radv;
    n_chk       = 0;
    n_pass      = 0;
    wr_rst_n    = 1'b0;
    wr_en       = 1'b0;
    ovf_clr     = 1'b0;
    rd_ptr_sync = 6'd0;
    model_reset();

    #2;
    chk("rst_wr_ptr",    32'(wr_ptr),        0);
    chk("rst_gray",      32'(wr_ptr_gray),   0);
    chk("rst_full",      32'(fifo_full),     0);
    chk("rst_almost",    32'(almost_full),   0);
    chk("rst_count",     32'(wr_data_count), 0);
    chk("rst_ram_wr_en", 32'(ram_wr_en),     0);
    chk("rst_ack",       32'(wr_ack),        0);
    chk("rst_ovf",       32'(overflow),      0);
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;

    // Fill from empty: eight accepted writes.
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 0);
    chk("fill_ptr",   32'(wr_ptr),        32);
    chk("fill_count", 32'(wr_data_count), 8);
    chk("fill_full",  32'(fifo_full),     1);

    // Overflow set, clear, and set-wins-over-clear.
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    chk("ovf_hold_ptr", 32'(wr_ptr), 32);
    do_cycle(1'b0, 1'b1, 0);
    do_cycle(1'b0, 1'b0, 0);
    chk("ovf_cleared", 32'(overflow), 0);
    do_cycle(1'b1, 1'b1, 0);
    do_cycle(1'b0, 1'b0, 0);
    chk("ovf_set_wins", 32'(overflow), 1);
    do_cycle(1'b0, 1'b1, 0);

    // Narrow reader frees one unit at a time; the write lands when rd_ptr_sync reaches 4.
    do_cycle(1'b0, 1'b0, 1);
    do_cycle(1'b0, 1'b0, 1);
    do_cycle(1'b0, 1'b0, 1);
    do_cycle(1'b1, 1'b0, 1);
    chk("narrow_ptr", 32'(wr_ptr), 36);

    // Walk to wr_ptr=60 with rd_ptr_sync=40, then write across the wrap.
    guard = 0;
    while (((wtot % 64) != 60 || (wtot - rtot) != 20) && guard < 100) begin
      do_cycle(logic'((wtot % 64) != 60), 1'b0, ((wtot - rtot) > 20) ? 4 : 0);
      guard++;
    end
    chk("wrap_setup", guard < 100 ? 1 : 0, 1);
    chk("wrap_pre_ptr", 32'(wr_ptr), 60);
    chk("wrap_pre_rd",  32'(rd_ptr_sync), 40);
    do_cycle(1'b1, 1'b0, 0);
    chk("wrap_ptr",   32'(wr_ptr),        0);
    chk("wrap_gray",  32'(wr_ptr_gray),   0);
    chk("wrap_count", 32'(wr_data_count), 6);
    do_cycle(1'b0, 1'b0, 0);

    // Random traffic, reader never passes the writer.
    for (int i = 0; i < 400; i++) begin
      occ  = wtot - rtot;
      radv = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 5));
      if (radv > occ) radv = occ;
      do_cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) == 0), radv);
    end

    // Fill, overflow, free space, then reset asynchronously in the middle of a burst.
    guard = 0;
    while ((32 - (wtot - rtot)) >= 4 && guard < 20) begin
      do_cycle(1'b1, 1'b0, 0);
      guard++;
    end
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b0, 1'b0, 12);
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    chk("pre_rst_ovf", 32'(overflow), 1);
    chk("pre_rst_ack", 32'(wr_ack),   1);
    #2;
    wr_rst_n    = 1'b0;
    wr_en       = 1'b0;
    rd_ptr_sync = 6'd0;
    #1;
    chk("arst_ptr",  32'(wr_ptr),      0);
    chk("arst_gray", 32'(wr_ptr_gray), 0);
    chk("arst_ack",  32'(wr_ack),      0);
    chk("arst_ovf",  32'(overflow),    0);
    model_reset();
    @(negedge wr_clk);
    wr_rst_n = 1'b1;
    @(posedge wr_clk);
    #1;
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    chk("post_rst_ptr", 32'(wr_ptr), 8);
    do_cycle(1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
